// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM register with branch/jump resolution, PC redirect and 2-entry skid buffer.
// Optional EXMEM_FWD_EN adds forwarding/load-use outputs from the main register.
module ex_mem_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [RA_W-1:0] rd,
  input  logic            ctl_reg_write,
  input  logic            ctl_mem_read,
  input  logic            ctl_mem_write,
  input  logic            ctl_mem_to_reg,
  input  logic [2:0]      funct3,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_store_data,
  output logic [RA_W-1:0] out_rd,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_mem_to_reg,
  output logic [2:0]      out_funct3,
`ifdef EXMEM_FWD_EN
  output logic            fwd_valid,
  output logic [RA_W-1:0] fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic            load_use,
`endif
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [RA_W-1:0] rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic [2:0]      funct3;
  } ent_t;
  ent_t main_q, skid_q, in_e;
  logic main_v, skid_v, accept, hs, taken;
  logic [XLEN-1:0] target;
  assign accept = in_valid & in_ready & ~flush;
  assign hs     = main_v & out_ready;
  assign taken  = (is_branch & alu_zero) | is_jal | is_jalr;
  assign target = is_jalr ? (alu_result & ~XLEN'(1)) : pc + imm;
  assign in_e   = '{
    result:     (is_jal | is_jalr) ? pc + XLEN'(4) : alu_result,
    store_data: rs2_data,
    rd:         rd,
    reg_write:  ctl_reg_write,
    mem_read:   ctl_mem_read,
    mem_write:  ctl_mem_write,
    mem_to_reg: ctl_mem_to_reg,
    funct3:     funct3
  };
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v         <= 1'b0;
      skid_v         <= 1'b0;
      main_q         <= '0;
      skid_q         <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else if (flush) begin
      main_v         <= 1'b0;
      skid_v         <= 1'b0;
      redirect_valid <= 1'b0;
    end else begin
      redirect_valid <= accept & taken;
      if (accept & taken) redirect_pc <= target;
      if (!main_v || hs) begin
        // the skid entry is older than anything on the input, so it drains first
        main_v <= skid_v | accept;
        skid_v <= 1'b0;
        if (skid_v) main_q <= skid_q;
        else if (accept) main_q <= in_e;
      end else if (accept) begin
        skid_v <= 1'b1;
        skid_q <= in_e;
      end
    end
  end
  assign in_ready       = ~skid_v;
  assign out_valid      = main_v;
  assign out_result     = main_q.result;
  assign out_store_data = main_q.store_data;
  assign out_rd         = main_q.rd;
  assign out_reg_write  = main_q.reg_write;
  assign out_mem_read   = main_q.mem_read;
  assign out_mem_write  = main_q.mem_write;
  assign out_mem_to_reg = main_q.mem_to_reg;
  assign out_funct3     = main_q.funct3;
`ifdef EXMEM_FWD_EN
  assign fwd_valid = main_v & main_q.reg_write & ~main_q.mem_to_reg & (main_q.rd != '0);
  assign fwd_rd    = main_q.rd;
  assign fwd_data  = main_q.result;
  assign load_use  = main_v & main_q.mem_to_reg & (main_q.rd != '0);
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed scenarios plus randomized run against a queue-based model of ex_mem_stage.
module tb_ex_mem_stage;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, in_ready;
  logic [31:0] alu_result = 0, pc = 0, imm = 0, rs2_data = 0;
  logic alu_zero = 0;
  logic [4:0] rd = 0;
  logic ctl_reg_write = 0, ctl_mem_read = 0, ctl_mem_write = 0, ctl_mem_to_reg = 0;
  logic [2:0] funct3 = 0;
  logic is_branch = 0, is_jal = 0, is_jalr = 0;
  logic out_valid, out_ready = 0;
  logic [31:0] out_result, out_store_data, redirect_pc;
  logic [4:0] out_rd;
  logic out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, redirect_valid;
  logic [2:0] out_funct3;
`ifdef EXMEM_FWD_EN
  logic fwd_valid, load_use;
  logic [4:0] fwd_rd;
  logic [31:0] fwd_data;
`endif
  int n_checks = 0, n_pass = 0;

  ex_mem_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_zero(alu_zero), .pc(pc), .imm(imm), .rs2_data(rs2_data),
    .rd(rd), .ctl_reg_write(ctl_reg_write), .ctl_mem_read(ctl_mem_read),
    .ctl_mem_write(ctl_mem_write), .ctl_mem_to_reg(ctl_mem_to_reg), .funct3(funct3),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_store_data(out_store_data), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_mem_to_reg(out_mem_to_reg), .out_funct3(out_funct3),
`ifdef EXMEM_FWD_EN
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .load_use(load_use),
`endif
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result, sd;
    logic [4:0] rd;
    logic rw, mr, mw, m2r;
    logic [2:0] f3;
  } pkt_t;
  pkt_t mq[$];
  logic m_rv = 0;
  logic [31:0] m_rpc = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    in_valid = 0; alu_result = 0; alu_zero = 0; pc = 0; imm = 0; rs2_data = 0; rd = 0;
    ctl_reg_write = 0; ctl_mem_read = 0; ctl_mem_write = 0; ctl_mem_to_reg = 0; funct3 = 0;
    is_branch = 0; is_jal = 0; is_jalr = 0; flush = 0;
  endtask

  function automatic pkt_t cur_pkt();
    pkt_t p;
    p.result = (is_jal || is_jalr) ? pc + 32'd4 : alu_result;
    p.sd = rs2_data; p.rd = rd; p.rw = ctl_reg_write; p.mr = ctl_mem_read;
    p.mw = ctl_mem_write; p.m2r = ctl_mem_to_reg; p.f3 = funct3;
    return p;
  endfunction

  // Model: an in-order queue of at most two held instructions.
  task automatic model_tick();
    bit hs, acc, tk;
    hs  = mq.size() > 0 && out_ready;
    acc = in_valid && mq.size() < 2 && !flush;
    tk  = (is_branch && alu_zero) || is_jal || is_jalr;
    if (rst || flush) begin
      mq.delete();
      m_rv = 0;
    end else begin
      if (hs) void'(mq.pop_front());
      if (acc) mq.push_back(cur_pkt());
      m_rv = acc && tk;
      if (m_rv) m_rpc = is_jalr ? alu_result - (alu_result % 2) : pc + imm;
    end
  endtask

  task automatic test_reset();
    rst = 1; clr_in(); out_ready = 0;
    step(); step();
    rst = 0;
    n_checks++; if (out_valid !== 0) $display("FAIL reset out_valid got %0b want 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1) $display("FAIL reset in_ready got %0b want 1", in_ready); else n_pass++;
    n_checks++; if (redirect_valid !== 0) $display("FAIL reset redirect_valid got %0b want 0", redirect_valid); else n_pass++;
    n_checks++; if (redirect_pc !== 0) $display("FAIL reset redirect_pc got %h want 0", redirect_pc); else n_pass++;
    n_checks++;
    if ({out_result, out_store_data, out_rd, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_funct3} !== '0)
      $display("FAIL reset outputs got %h/%h/%h want 0", out_result, out_store_data, out_rd);
    else n_pass++;
  endtask

  task automatic test_basic();
    clr_in(); out_ready = 1;
    in_valid = 1; alu_result = 32'h1234; rd = 5; ctl_reg_write = 1;
    step(); in_valid = 0;
    n_checks++; if (out_valid !== 1) $display("FAIL basic out_valid got %0b want 1", out_valid); else n_pass++;
    n_checks++; if (out_result !== 32'h1234) $display("FAIL basic out_result got %h want 1234", out_result); else n_pass++;
    n_checks++; if (out_rd !== 5 || out_reg_write !== 1) $display("FAIL basic rd/rw got %0d/%0b want 5/1", out_rd, out_reg_write); else n_pass++;
    step();
    n_checks++; if (out_valid !== 0) $display("FAIL basic drain out_valid got %0b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_branch();
    clr_in(); out_ready = 1;
    in_valid = 1; pc = 32'h100; imm = 32'h20; is_branch = 1; alu_zero = 1;
    step(); in_valid = 0;
    n_checks++; if (redirect_valid !== 1) $display("FAIL branch_taken redirect_valid got %0b want 1", redirect_valid); else n_pass++;
    n_checks++; if (redirect_pc !== 32'h120) $display("FAIL branch_taken redirect_pc got %h want 120", redirect_pc); else n_pass++;
    step();
    n_checks++; if (redirect_valid !== 0) $display("FAIL branch_pulse redirect_valid got %0b want 0", redirect_valid); else n_pass++;
    in_valid = 1; alu_zero = 0;
    step(); in_valid = 0;
    n_checks++; if (redirect_valid !== 0) $display("FAIL branch_not_taken redirect_valid got %0b want 0", redirect_valid); else n_pass++;
    n_checks++; if (out_valid !== 1) $display("FAIL branch_not_taken out_valid got %0b want 1", out_valid); else n_pass++;
    step();
  endtask

  task automatic test_jump();
    clr_in(); out_ready = 1;
    in_valid = 1; is_jalr = 1; alu_result = 32'h205; pc = 32'h40;
    step();
    n_checks++; if (redirect_valid !== 1 || redirect_pc !== 32'h204) $display("FAIL jalr redirect got %0b/%h want 1/204", redirect_valid, redirect_pc); else n_pass++;
    n_checks++; if (out_result !== 32'h44) $display("FAIL jalr out_result got %h want 44", out_result); else n_pass++;
    is_jalr = 0; is_jal = 1; pc = 32'hFFFF_FFFC; imm = 32'd8;
    step(); in_valid = 0;
    n_checks++; if (redirect_valid !== 1 || redirect_pc !== 32'h4) $display("FAIL jal_wrap redirect got %0b/%h want 1/4", redirect_valid, redirect_pc); else n_pass++;
    n_checks++; if (out_result !== 32'h0) $display("FAIL jal_wrap out_result got %h want 0", out_result); else n_pass++;
    step();
    n_checks++; if (out_valid !== 0 || redirect_valid !== 0) $display("FAIL jump_drain valid got %0b/%0b want 0/0", out_valid, redirect_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    clr_in(); out_ready = 0;
    in_valid = 1; alu_result = 32'hA; rd = 1;
    step();
    n_checks++; if (out_valid !== 1 || out_result !== 32'hA || in_ready !== 1) $display("FAIL b2b_A got %0b/%h/%0b want 1/a/1", out_valid, out_result, in_ready); else n_pass++;
    alu_result = 32'hB; rd = 2;
    step();
    n_checks++; if (out_result !== 32'hA || in_ready !== 0) $display("FAIL b2b_B_skid got %h/%0b want a/0", out_result, in_ready); else n_pass++;
    alu_result = 32'hC; rd = 3;
    step();
    n_checks++; if (out_result !== 32'hA || out_rd !== 1 || in_ready !== 0) $display("FAIL b2b_hold got %h/%0d/%0b want a/1/0", out_result, out_rd, in_ready); else n_pass++;
    out_ready = 1;
    step();
    n_checks++; if (out_valid !== 1 || out_result !== 32'hB || out_rd !== 2 || in_ready !== 1) $display("FAIL b2b_emit_B got %0b/%h/%0d/%0b want 1/b/2/1", out_valid, out_result, out_rd, in_ready); else n_pass++;
    step(); in_valid = 0;
    n_checks++; if (out_valid !== 1 || out_result !== 32'hC || out_rd !== 3) $display("FAIL b2b_emit_C got %0b/%h/%0d want 1/c/3", out_valid, out_result, out_rd); else n_pass++;
    step();
    n_checks++; if (out_valid !== 0) $display("FAIL b2b_empty out_valid got %0b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_flush();
    clr_in(); out_ready = 0;
    in_valid = 1; ctl_reg_write = 1; rd = 7; alu_result = 32'h11;
    step(); step();
    n_checks++; if (in_ready !== 0 || out_valid !== 1) $display("FAIL flush_prefill got %0b/%0b want 0/1", in_ready, out_valid); else n_pass++;
`ifdef EXMEM_FWD_EN
    n_checks++; if (fwd_valid !== 1) $display("FAIL flush_prefill fwd_valid got %0b want 1", fwd_valid); else n_pass++;
`endif
    pc = 32'h100; imm = 32'h20; is_branch = 1; alu_zero = 1; flush = 1;
    step(); flush = 0; in_valid = 0;
    n_checks++; if (out_valid !== 0 || in_ready !== 1 || redirect_valid !== 0) $display("FAIL flush_full got %0b/%0b/%0b want 0/1/0", out_valid, in_ready, redirect_valid); else n_pass++;
`ifdef EXMEM_FWD_EN
    n_checks++; if (fwd_valid !== 0 || load_use !== 0) $display("FAIL flush_fwd got %0b/%0b want 0/0", fwd_valid, load_use); else n_pass++;
`endif
    is_branch = 0; in_valid = 1;
    step();
    in_valid = 1; is_branch = 1; flush = 1;
    step(); flush = 0; in_valid = 0;
    n_checks++; if (out_valid !== 0 || in_ready !== 1 || redirect_valid !== 0) $display("FAIL flush_taken got %0b/%0b/%0b want 0/1/0", out_valid, in_ready, redirect_valid); else n_pass++;
    step();
    n_checks++; if (redirect_valid !== 0 || out_valid !== 0) $display("FAIL flush_after got %0b/%0b want 0/0", redirect_valid, out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    clr_in(); out_ready = 0;
    in_valid = 1; alu_result = 32'h77; rd = 9;
    step(); step();
    is_jal = 1; pc = 32'h300; imm = 32'h10; rst = 1;
    step(); rst = 0; clr_in();
    n_checks++; if (out_valid !== 0 || in_ready !== 1 || redirect_valid !== 0) $display("FAIL reset_mid got %0b/%0b/%0b want 0/1/0", out_valid, in_ready, redirect_valid); else n_pass++;
    n_checks++; if (redirect_pc !== 0 || out_result !== 0 || out_rd !== 0) $display("FAIL reset_mid data got %h/%h/%0d want 0/0/0", redirect_pc, out_result, out_rd); else n_pass++;
  endtask

`ifdef EXMEM_FWD_EN
  task automatic test_fwd();
    clr_in(); out_ready = 1;
    in_valid = 1; ctl_reg_write = 1; rd = 3; alu_result = 32'h55;
    step();
    n_checks++; if (fwd_valid !== 1 || fwd_rd !== 3 || fwd_data !== 32'h55 || load_use !== 0) $display("FAIL fwd_alu got %0b/%0d/%h/%0b want 1/3/55/0", fwd_valid, fwd_rd, fwd_data, load_use); else n_pass++;
    ctl_mem_to_reg = 1; ctl_mem_read = 1; rd = 4;
    step();
    n_checks++; if (fwd_valid !== 0 || load_use !== 1) $display("FAIL fwd_load got %0b/%0b want 0/1", fwd_valid, load_use); else n_pass++;
    ctl_mem_to_reg = 0; ctl_mem_read = 0; rd = 0;
    step(); in_valid = 0;
    n_checks++; if (fwd_valid !== 0 || load_use !== 0) $display("FAIL fwd_x0 got %0b/%0b want 0/0", fwd_valid, load_use); else n_pass++;
    step();
  endtask
`endif

  task automatic test_random();
    pkt_t e;
    clr_in(); rst = 1; out_ready = 0;
    model_tick(); step(); rst = 0;
    for (int i = 0; i < 600; i++) begin
      int k;
      in_valid = $urandom_range(0, 3) != 0;
      alu_result = $urandom; alu_zero = $urandom_range(0, 1); pc = $urandom; imm = $urandom;
      rs2_data = $urandom; rd = 5'($urandom); funct3 = 3'($urandom);
      ctl_reg_write = 1'($urandom); ctl_mem_read = 1'($urandom);
      ctl_mem_write = 1'($urandom); ctl_mem_to_reg = 1'($urandom);
      k = $urandom_range(0, 3);
      is_branch = k == 1; is_jal = k == 2; is_jalr = k == 3;
      out_ready = $urandom_range(0, 1);
      flush = $urandom_range(0, 31) == 0;
      rst = $urandom_range(0, 99) == 0;
      model_tick();
      step();
      rst = 0;
      n_checks++; if (in_ready !== (mq.size() < 2)) $display("FAIL rand_in_ready cyc %0d got %0b want %0b", i, in_ready, mq.size() < 2); else n_pass++;
      n_checks++; if (out_valid !== (mq.size() > 0)) $display("FAIL rand_out_valid cyc %0d got %0b want %0b", i, out_valid, mq.size() > 0); else n_pass++;
      if (mq.size() > 0) begin
        e = mq[0];
        n_checks++;
        if ({out_result, out_store_data, out_rd, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_funct3} !==
            {e.result, e.sd, e.rd, e.rw, e.mr, e.mw, e.m2r, e.f3})
          $display("FAIL rand_pkt cyc %0d got %h/%h/%0d want %h/%h/%0d", i, out_result, out_store_data, out_rd, e.result, e.sd, e.rd);
        else n_pass++;
`ifdef EXMEM_FWD_EN
        n_checks++;
        if (fwd_valid !== (e.rw && !e.m2r && e.rd != 0) || load_use !== (e.m2r && e.rd != 0))
          $display("FAIL rand_fwd cyc %0d got %0b/%0b", i, fwd_valid, load_use);
        else n_pass++;
`endif
      end
      n_checks++; if (redirect_valid !== m_rv) $display("FAIL rand_redirect_valid cyc %0d got %0b want %0b", i, redirect_valid, m_rv); else n_pass++;
      if (m_rv) begin
        n_checks++; if (redirect_pc !== m_rpc) $display("FAIL rand_redirect_pc cyc %0d got %h want %h", i, redirect_pc, m_rpc); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_branch();
    test_jump();
    test_back_to_back();
    test_flush();
    test_reset_mid();
`ifdef EXMEM_FWD_EN
    test_fwd();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
EX→MEM pipeline stage directly downstream of the ALU.
- Captures the ALU result/zero flag plus the instruction's control bundle.
- Resolves branches and jumps: the ALU branch encodings return 0 when the condition holds, so zero=1 means taken.
- Emits a one-cycle PC redirect.
- Presents a registered, valid/ready-handshaked packet to the MEM stage, with a 2-entry skid buffer so back-pressure never drops an instruction.

Parameters:
XLEN, 32, datapath width (result, PC, immediate, store data)
RA_W, 5, register-address width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  kill all held entries and any input this cycle
in_valid  in  1  EX has a valid instruction
in_ready  out  1  stage can accept; registered, equals !skid_valid
alu_result  in  XLEN  ALU result
alu_zero  in  1  ALU zero flag
pc  in  XLEN  instruction PC
imm  in  XLEN  sign-extended immediate
rs2_data  in  XLEN  store data
rd  in  RA_W  destination register
ctl_reg_write, ctl_mem_read, ctl_mem_write, ctl_mem_to_reg  in  1 each  pass-through controls
funct3  in  3  memory access size/sign
is_branch, is_jal, is_jalr  in  1 each  control-flow type (one-hot or none)
out_valid  out  1  packet valid to MEM
out_ready  in  1  MEM accepts
out_result  out  XLEN  ALU result, or pc+4 for jal/jalr
out_store_data  out  XLEN  registered rs2_data
out_rd  out  RA_W  registered rd
out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg  out  1 each  registered controls
out_funct3  out  3  registered funct3
redirect_valid  out  1  one-cycle pulse, PC redirect
redirect_pc  out  XLEN  redirect target

Behaviour:
- Accept = in_valid & in_ready & !flush. Out-handshake = out_valid & out_ready.
- Taken on accept:
  - (is_branch & alu_zero) → target pc+imm
  - is_jal → target pc+imm
  - is_jalr → target (alu_result) & ~1
- Result selection: jal/jalr write pc+4 into the result field; otherwise alu_result. All adds are modulo 2^XLEN (wrap, no overflow flag).
- Redirect timing: redirect_valid/redirect_pc are registered, asserting the cycle after an accepted taken instruction, for exactly 1 cycle. Not-taken or flushed instructions never redirect.
- Storage: main register (drives outputs) + skid register.
  - Main empty, or out-handshake: main ← skid if skid_valid, else ← input if accept, else invalid.
  - Main full, no out-handshake, accept: input → skid.
  - in_ready = !skid_valid. Skid can never be written while full.
  - Simultaneous accept + out-handshake with skid full cannot occur (in_ready=0).
- Ordering is strict FIFO; no drops or duplicates.
- Flush (priority over everything except rst):
  - next cycle out_valid=0 and skid_valid=0;
  - input ignored;
  - redirect_valid=0 next cycle, including a redirect that would otherwise fire.
- Reset: out_valid=0, skid_valid=0, in_ready=1 after reset, redirect_valid=0, redirect_pc=0. All data/control outputs = 0.
- Reset mid-operation discards both entries; no redirect emitted.
- Outputs are stable while out_valid & !out_ready (hold rule).

Optional Feature:
EXMEM_FWD_EN
- Defined: adds outputs fwd_valid(1), fwd_rd(RA_W), fwd_data(XLEN), load_use(1), all driven from the main register:
  - fwd_valid = out_valid & out_reg_write & !out_mem_to_reg & (out_rd≠0);
  - fwd_data = out_result;
  - load_use = out_valid & out_mem_to_reg & (out_rd≠0).
- Undefined: these ports do not exist; no forwarding logic is generated.

Test Plan:
- Reset held 2 cycles, then released → out_valid=0, in_ready=1, redirect_valid=0, all outputs 0.
- Accept alu_result=0x1234, rd=5, reg_write=1, out_ready=1 → next cycle out_valid=1, out_result=0x1234, out_rd=5; following cycle out_valid=0.
- Branch pc=0x100, imm=0x20, is_branch=1, alu_zero=1 → redirect_valid pulses 1 cycle with redirect_pc=0x120. Same with alu_zero=0 → no redirect.
- jalr alu_result=0x205, pc=0x40 → redirect_pc=0x204, out_result=0x44. jal pc=0xFFFFFFFC, imm=8 → redirect_pc=0x4 (wrap).
- Back-pressure: out_ready=0, three back-to-back in_valid values A,B,C.
  - Expected: A in main, B in skid, in_ready=0, C held by source.
  - Release out_ready → A,B,C emerge in order, none lost.
- Flush with both entries full plus a taken branch arriving → next cycle out_valid=0, in_ready=1, no redirect. With EXMEM_FWD_EN, fwd_valid=0 and load_use=0.
